dm_stage: RTL

DM_STAGE -- requirements
Module: dm_stage

---
 rtl/dm_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dm_stage.sv
// Data-memory stage: a three-state IDLE/ACCESS/DONE sequencer in front of a 2^AW-word
// byte-lane memory. Define DM_ALIGN_CHECK_EN to flag misaligned word/half accesses.
//
//   state  | meaning
//   IDLE   | waiting for req; captures op/addr/wdata on accept
//   ACCESS | memory read/write, load result captured
//   DONE   | done pulse, rdata/err presented
module dm_stage #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  state_t          state, state_nx;
  logic [2:0]      op_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [31:0]     mem [0:(2**AW)-1];
  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [1:0]      lane;
  logic            is_word, is_half, is_store, misalign;
  logic [7:0]      sel_b;
  logic [15:0]     sel_h;
  logic [31:0]     ld_data;
  logic [3:0]      be;
  logic [31:0]     wr_data;
  logic            we;

  // Address bits above the memory window are intentionally ignored (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, addr[31:AW+2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        op_q    <= op;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
      end
      if (state == ACCESS) begin
        rdata_q <= ld_data;
        err_q   <= misalign;
      end
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    if (req) state_nx = ACCESS;
      ACCESS: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rdata = done ? rdata_q : 32'h0;
  assign err   = done ? err_q   : 1'b0;

  assign is_word  = (op_q == OP_LW) || (op_q == OP_SW);
  assign is_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
  assign is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);

`ifdef DM_ALIGN_CHECK_EN
  assign misalign = (is_word && addr_q[1:0] != 2'b00) || (is_half && addr_q[0]);
  assign lane     = addr_q[1:0];
`else
  assign misalign = 1'b0;
  assign lane     = is_word ? 2'b00 : (is_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
`endif

  assign idx  = addr_q[AW+1:2];
  assign word = mem[idx];

  always_comb begin
    sel_b = word[7:0];
    case (lane)
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      2'd3:    sel_b = word[31:24];
      default: sel_b = word[7:0];
    endcase
    sel_h = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    ld_data = 32'h0;
    case (op_q)
      OP_LW:   ld_data = word;
      OP_LH:   ld_data = {{16{sel_h[15]}}, sel_h};
      OP_LHU:  ld_data = {16'h0, sel_h};
      OP_LB:   ld_data = {{24{sel_b[7]}}, sel_b};
      OP_LBU:  ld_data = {24'h0, sel_b};
      default: ld_data = 32'h0;
    endcase
    if (misalign) ld_data = 32'h0;
  end

  always_comb begin
    be      = 4'b0000;
    wr_data = wdata_q;
    case (op_q)
      OP_SW: be = 4'b1111;
      OP_SH: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      OP_SB: begin
        be      = 4'b0001 << lane;
        wr_data = {4{wdata_q[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  // Reset wins over a store sitting in ACCESS.
  assign we = !rst && (state == ACCESS) && is_store && !misalign;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

endmodule
